// File: rtl/cpu_req_buffer.sv
`default_nettype none
// cpu_req_buffer: in-order CPU request FIFO feeding the cache word port, one request in flight.
// Define REQ_BUF_TIMEOUT_EN to enable the response watchdog (err_timeout, forced completion).
module cpu_req_buffer #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TAG_W          = 4,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_rw,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_wdata,
    input  logic [DATA_W/8-1:0]      in_wstrb,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     cache_req_valid,
    input  logic                     cache_req_ready,
    output logic                     cache_req_rw,
    output logic [ADDR_W-1:0]        cache_addr,
    output logic [DATA_W-1:0]        cache_wdata,
    output logic [DATA_W/8-1:0]      cache_wstrb,
    input  logic                     cache_resp_valid,
    input  logic [DATA_W-1:0]        cache_rdata,
    output logic                     out_resp_valid,
    output logic                     out_resp_rw,
    output logic [TAG_W-1:0]         out_resp_tag,
    output logic [DATA_W-1:0]        out_resp_rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_unexpected,
    output logic                     err_timeout
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;

    logic              mem_rw    [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];
    logic [STRB_W-1:0] mem_wstrb [DEPTH];
    logic [TAG_W-1:0]  mem_tag   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              timeout_hit;
    logic              flight_rw;
    logic [TAG_W-1:0]  flight_tag;

    // No bypass: a full buffer refuses pushes even in a cycle where the head pops.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = cache_req_valid && cache_req_ready;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Head of the FIFO is presented only while a request is being offered.
    assign cache_req_rw = cache_req_valid && mem_rw[rd_ptr];
    assign cache_addr   = cache_req_valid ? mem_addr[rd_ptr]  : '0;
    assign cache_wdata  = cache_req_valid ? mem_wdata[rd_ptr] : '0;
    assign cache_wstrb  = cache_req_valid ? mem_wstrb[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rw[wr_ptr]    <= in_rw;
            mem_addr[wr_ptr]  <= in_addr;
            mem_wdata[wr_ptr] <= in_wdata;
            mem_wstrb[wr_ptr] <= in_wstrb;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            cache_req_valid <= 1'b0;
            flight_rw       <= 1'b0;
            flight_tag      <= '0;
            out_resp_valid  <= 1'b0;
            out_resp_rw     <= 1'b0;
            out_resp_tag    <= '0;
            out_resp_rdata  <= '0;
            err_unexpected  <= 1'b0;
        end else begin
            out_resp_valid <= 1'b0;
            count          <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (cache_resp_valid && (state != S_WAIT)) begin
                err_unexpected <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state           <= S_ISSUE;
                        cache_req_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cache_req_ready) begin
                        state           <= S_WAIT;
                        cache_req_valid <= 1'b0;
                        flight_rw       <= mem_rw[rd_ptr];
                        flight_tag      <= mem_tag[rd_ptr];
                    end
                end
                S_WAIT: begin
                    // A watchdog expiry completes the request exactly like a response, with zero data.
                    if (cache_resp_valid || timeout_hit) begin
                        out_resp_valid <= 1'b1;
                        out_resp_rw    <= flight_rw;
                        out_resp_tag   <= flight_tag;
                        out_resp_rdata <= (cache_resp_valid && !flight_rw) ? cache_rdata : '0;
                        if (count_next != '0) begin
                            state           <= S_ISSUE;
                            cache_req_valid <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    cache_req_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef REQ_BUF_TIMEOUT_EN
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] wait_cnt;

    // wait_cnt equals the number of completed WAIT cycles; it restarts from zero on every WAIT entry.
    assign timeout_hit = (state == S_WAIT) && !cache_resp_valid && (wait_cnt == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + TMR_W'(1) : '0;
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
`default_nettype wire
